// File: rtl/alu_seq_pkg.sv
// Shared types, status codes and opcode set for the ALU command sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_OP    = 3'd1,
    ST_GET_A     = 3'd2,
    ST_GET_B     = 3'd3,
    ST_EXEC      = 3'd4,
    ST_SEND      = 3'd5,
    ST_WAIT_DONE = 3'd6
  } state_t;

  localparam logic [7:0] STATUS_OK     = 8'h00;
  localparam logic [7:0] STATUS_BAD_OP = 8'h01;

  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_SRL = 8'h02;

  // An opcode byte is accepted only if it is a known ALU operation and
  // carries nothing above the opcode field width.
  function automatic logic is_valid_op(input logic [7:0] op, input int op_bits);
    logic [7:0] high_mask;
    logic       known;
    high_mask = (op_bits >= 8) ? 8'h00 : ~8'((32'd1 << op_bits) - 32'd1);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: known = 1'b1;
      default: known = 1'b0;
    endcase
    return known && ((op & high_mask) == 8'h00);
  endfunction

endpackage

// File: rtl/alu_seq_rx_timer.sv
// Inter-byte timeout counter: cleared by a pop, counts while enabled,
// flags expiry when it reaches TIMEOUT_CYCLES. Disabled when TIMEOUT_CYCLES=0.
module alu_seq_rx_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] cnt;

      // Count idle cycles; saturate at the limit so it never wraps.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt <= '0;
        end else if (clr || !en) begin
          cnt <= '0;
        end else if (cnt != CW'(TIMEOUT_CYCLES)) begin
          cnt <= cnt + 1'b1;
        end
      end

      // A pop in the expiry cycle takes priority over the timeout.
      assign expired = en && !clr && (cnt == CW'(TIMEOUT_CYCLES));
    end
  endgenerate

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Assembles opcode/A/B frames from the UART RX FIFO, drives the ALU operands,
// and returns the result bytes plus a status byte on the UART TX side.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N_BITS_DATA    = 16,
  parameter int N_BITS_OP      = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_empty_i,
  input  logic [7:0]             rx_data_i,
  output logic                   rd_uart_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_start_o,
  input  logic                   tx_done_tick_i,
  output logic [N_BITS_DATA-1:0] dataA_o,
  output logic [N_BITS_DATA-1:0] dataB_o,
  output logic [N_BITS_OP-1:0]   dataOp_o,
  input  logic [N_BITS_DATA-1:0] result_alu_i,
  output logic                   busy_o,
  output logic                   frame_err_o
);

  localparam int N_BYTES = N_BITS_DATA / 8;
  localparam int BCW     = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int IW      = BCW + 1;

  state_t                 state;
  logic                   pop_hold;
  logic [BCW-1:0]         byte_cnt;
  logic                   op_ok;
  logic [N_BITS_DATA-1:0] result_q;
  logic [IW-1:0]          tx_idx;
  logic [IW-1:0]          nxt_idx;
  logic [7:0]             tx_next;
  logic                   pop;
  logic                   rx_state;
  logic                   tmr_en;
  logic                   tmr_expired;

  // pop_hold is set out of reset and after every pop, giving the one-cycle gap
  // between pops and keeping rd_uart_o low while reset is held.
  assign rx_state  = (state == ST_IDLE) || (state == ST_GET_OP) ||
                     (state == ST_GET_A) || (state == ST_GET_B);
  assign pop       = !rx_empty_i && rx_state && !pop_hold;
  assign rd_uart_o = pop;
  assign tmr_en    = (state == ST_GET_A) || (state == ST_GET_B);
  assign nxt_idx   = tx_idx + 1'b1;

  alu_seq_rx_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_timer (
    .clock  (clock),
    .reset  (reset),
    .clr    (pop),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  // Select the next TX byte: result bytes LSB first, then the status byte.
  always_comb begin
    tx_next = op_ok ? STATUS_OK : STATUS_BAD_OP;
    for (int k = 0; k < N_BYTES; k++) begin
      if (nxt_idx == IW'(k)) tx_next = result_q[8*k +: 8];
    end
  end

  // Frame FSM with operand assembly, result latch and registered TX controls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pop_hold    <= 1'b1;
      byte_cnt    <= '0;
      op_ok       <= 1'b0;
      result_q    <= '0;
      tx_idx      <= '0;
      dataA_o     <= '0;
      dataB_o     <= '0;
      dataOp_o    <= '0;
      tx_data_o   <= 8'h00;
      tx_start_o  <= 1'b0;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      pop_hold    <= pop;
      tx_start_o  <= 1'b0;
      frame_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            dataOp_o <= rx_data_i[N_BITS_OP-1:0];
            op_ok    <= is_valid_op(rx_data_i, N_BITS_OP);
            dataA_o  <= '0;
            dataB_o  <= '0;
            byte_cnt <= '0;
            busy_o   <= 1'b1;
            state    <= ST_GET_OP;
          end
        end
        ST_GET_OP: state <= ST_GET_A;
        ST_GET_A: begin
          if (pop) begin
            for (int k = 0; k < N_BYTES; k++) begin
              if (byte_cnt == BCW'(k)) dataA_o[8*k +: 8] <= rx_data_i;
            end
            if (byte_cnt == BCW'(N_BYTES - 1)) begin
              byte_cnt <= '0;
              state    <= ST_GET_B;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (tmr_expired) begin
            frame_err_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_GET_B: begin
          if (pop) begin
            for (int k = 0; k < N_BYTES; k++) begin
              if (byte_cnt == BCW'(k)) dataB_o[8*k +: 8] <= rx_data_i;
            end
            if (byte_cnt == BCW'(N_BYTES - 1)) begin
              byte_cnt <= '0;
              state    <= ST_EXEC;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (tmr_expired) begin
            frame_err_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          result_q   <= op_ok ? result_alu_i : '0;
          tx_data_o  <= op_ok ? result_alu_i[7:0] : 8'h00;
          tx_idx     <= '0;
          tx_start_o <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: state <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (tx_done_tick_i) begin
            if (tx_idx == IW'(N_BYTES)) begin
              busy_o <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              tx_idx     <= nxt_idx;
              tx_data_o  <= tx_next;
              tx_start_o <= 1'b1;
              state      <= ST_SEND;
            end
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: FIFO and UART stand-ins, a stand-in ALU and a
// frame-level reference model with a per-cycle compare process.
module tb_alu_cmd_sequencer;

  localparam int DW  = 16;
  localparam int OPW = 6;
  localparam int TO  = 50;
  localparam int NB  = DW / 8;

  logic          clock;
  logic          reset;
  logic          rx_empty_i;
  logic [7:0]    rx_data_i;
  logic          rd_uart_o;
  logic [7:0]    tx_data_o;
  logic          tx_start_o;
  logic          tx_done_tick_i;
  logic [DW-1:0] dataA_o;
  logic [DW-1:0] dataB_o;
  logic [OPW-1:0] dataOp_o;
  logic [DW-1:0] result_alu_i;
  logic          busy_o;
  logic          frame_err_o;

  alu_cmd_sequencer #(
    .N_BITS_DATA(DW),
    .N_BITS_OP(OPW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_empty_i    (rx_empty_i),
    .rx_data_i     (rx_data_i),
    .rd_uart_o     (rd_uart_o),
    .tx_data_o     (tx_data_o),
    .tx_start_o    (tx_start_o),
    .tx_done_tick_i(tx_done_tick_i),
    .dataA_o       (dataA_o),
    .dataB_o       (dataB_o),
    .dataOp_o      (dataOp_o),
    .result_alu_i  (result_alu_i),
    .busy_o        (busy_o),
    .frame_err_o   (frame_err_o)
  );

  // Stand-in combinational ALU (MIPS-style function codes)
  function automatic logic [DW-1:0] alu_ref(input logic [7:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      8'h20:   return a + b;
      8'h22:   return a - b;
      8'h24:   return a & b;
      8'h25:   return a | b;
      8'h26:   return a ^ b;
      8'h27:   return ~(a | b);
      8'h03:   return DW'($signed(a) >>> b);
      8'h02:   return a >> b;
      default: return '0;
    endcase
  endfunction

  logic [7:0] valid_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

  function automatic bit ref_valid(input logic [7:0] op);
    bit hit = 0;
    for (int i = 0; i < 8; i++) if (op == valid_ops[i]) hit = 1;
    return hit && ((op >> OPW) == 0);
  endfunction

  always_comb result_alu_i = alu_ref({{(8 - OPW){1'b0}}, dataOp_o}, dataA_o, dataB_o);

  logic [7:0] fifo [$];
  logic [7:0] exp_q [$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, pop_count = 0, err_count = 0, err_cyc = 0, last_pop_cyc = 0;
  int tx_starts = 0, done_count = 0, sent_in_frame = 0, uart_cnt = 0;
  bit sending = 0, prev_rd = 0, inflight_v = 0, pop_now = 0;
  logic [7:0] inflight = 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare process plus FIFO and UART-TX stand-ins
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      pop_now = 0;
      if (!reset) begin
        prev_rd = 0; sending = 0; sent_in_frame = 0; inflight_v = 0;
      end else begin
        if (rd_uart_o) begin
          chk("pop_nonempty", 64'(rx_empty_i), 64'(0));
          chk("pop_spacing", 64'(prev_rd), 64'(0));
          chk("pop_while_sending", 64'(sending), 64'(0));
          last_pop_cyc = cyc;
          pop_count++;
          pop_now = 1;
        end
        prev_rd = rd_uart_o;
        if (tx_start_o) begin
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_tx: byte 0x%0h sent, no response byte pending", tx_data_o);
          end else begin
            chk("tx_byte", 64'(tx_data_o), 64'(exp_q.pop_front()));
          end
          inflight = tx_data_o; inflight_v = 1; sending = 1;
          sent_in_frame++; tx_starts++;
          uart_cnt = $urandom_range(1, 4);
        end else if (inflight_v) begin
          chk("tx_hold", 64'(tx_data_o), 64'(inflight));
        end
        if (frame_err_o) begin err_count++; err_cyc = cyc; end
        if (tx_done_tick_i) begin
          inflight_v = 0; done_count++;
          if (sent_in_frame == NB + 1) begin sending = 0; sent_in_frame = 0; end
        end
      end
      @(posedge clock); #1;
      if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
      tx_done_tick_i = 1'b0;
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) tx_done_tick_i = 1'b1;
      end
      rx_empty_i = (fifo.size() == 0);
      rx_data_i  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd"},    64'(rd_uart_o), 64'(0));
    chk({tag, "_start"}, 64'(tx_start_o), 64'(0));
    chk({tag, "_txd"},   64'(tx_data_o), 64'(0));
    chk({tag, "_A"},     64'(dataA_o), 64'(0));
    chk({tag, "_B"},     64'(dataB_o), 64'(0));
    chk({tag, "_Op"},    64'(dataOp_o), 64'(0));
    chk({tag, "_busy"},  64'(busy_o), 64'(0));
    chk({tag, "_ferr"},  64'(frame_err_o), 64'(0));
  endtask

  task automatic push5(input logic [7:0] b0, b1, b2, b3, b4);
    fifo.push_back(b0); fifo.push_back(b1); fifo.push_back(b2);
    fifo.push_back(b3); fifo.push_back(b4);
  endtask

  task automatic expect3(input logic [7:0] e0, e1, e2);
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0 || sending || busy_o) && n < budget) begin
      @(negedge clock); n++;
    end
    chk({name, "_completes"}, 64'(n < budget), 64'(1));
  endtask

  initial begin
    int e0, t0, p0, d0, n;
    logic [7:0] op;
    logic [DW-1:0] a, b, r;
    reset = 1'b0; rx_empty_i = 1'b1; rx_data_i = 8'h00; tx_done_tick_i = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_outputs("post_reset");

    // ADD
    push5(8'h20, 8'h34, 8'h12, 8'h01, 8'h00);
    expect3(8'h35, 8'h12, 8'h00);
    wait_quiet("add", 200);
    chk("add_A", 64'(dataA_o), 64'h1234);
    chk("add_B", 64'(dataB_o), 64'h0001);
    chk("add_Op", 64'(dataOp_o), 64'h20);

    // SUB with wrap
    push5(8'h22, 8'h00, 8'h00, 8'h01, 8'h00);
    expect3(8'hFF, 8'hFF, 8'h00);
    wait_quiet("sub", 200);

    // Bad opcode: frame still fully consumed
    p0 = pop_count;
    push5(8'hE0, 8'h11, 8'h22, 8'h33, 8'h44);
    expect3(8'h00, 8'h00, 8'h01);
    wait_quiet("badop", 200);
    chk("badop_pops", 64'(pop_count - p0), 64'(5));

    // Timeout after a partial frame
    e0 = err_count; t0 = tx_starts;
    fifo.push_back(8'h20); fifo.push_back(8'h34);
    n = 0;
    while (fifo.size() != 0 && n < 20) begin @(negedge clock); n++; end
    chk("partial_popped", 64'(n < 20), 64'(1));
    n = 0;
    while (err_count == e0 && n < TO + 20) begin @(negedge clock); n++; end
    repeat (5) @(negedge clock);
    chk("timeout_pulses", 64'(err_count - e0), 64'(1));
    chk("timeout_latency_ok", 64'((err_cyc - last_pop_cyc >= TO) && (err_cyc - last_pop_cyc <= TO + 3)), 64'(1));
    chk("timeout_no_tx", 64'(tx_starts - t0), 64'(0));
    chk("timeout_idle", 64'(busy_o), 64'(0));
    push5(8'h20, 8'h34, 8'h12, 8'h01, 8'h00);
    expect3(8'h35, 8'h12, 8'h00);
    wait_quiet("after_timeout", 200);
    chk("after_timeout_A", 64'(dataA_o), 64'h1234);

    // Back-to-back frames preloaded
    p0 = pop_count;
    push5(8'h20, 8'hFF, 8'h00, 8'h01, 8'h00);
    push5(8'h26, 8'hF0, 8'hF0, 8'hF0, 8'h0F);
    expect3(8'h00, 8'h01, 8'h00);
    expect3(8'h00, 8'hFF, 8'h00);
    wait_quiet("b2b", 400);
    chk("b2b_pops", 64'(pop_count - p0), 64'(10));

    // Reset in the middle of sending
    d0 = done_count;
    push5(8'h20, 8'h34, 8'h12, 8'h01, 8'h00);
    expect3(8'h35, 8'h12, 8'h00);
    n = 0;
    while (done_count == d0 && n < 200) begin @(negedge clock); n++; end
    chk("first_byte_done", 64'(n < 200), 64'(1));
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("midsend_reset");
    fifo.delete(); exp_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    push5(8'h22, 8'h00, 8'h00, 8'h01, 8'h00);
    expect3(8'hFF, 8'hFF, 8'h00);
    wait_quiet("after_reset", 200);

    // Randomized frames against the reference model
    e0 = err_count;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 3) == 0) op = 8'($urandom_range(0, 255));
      else op = valid_ops[$urandom_range(0, 7)];
      a = DW'($urandom);
      b = (op == 8'h02 || op == 8'h03) ? DW'($urandom_range(0, 17)) : DW'($urandom);
      r = ref_valid(op) ? alu_ref(op, a, b) : '0;
      expect3(r[7:0], r[15:8], ref_valid(op) ? 8'h00 : 8'h01);
      fifo.push_back(op);
      repeat ($urandom_range(0, 6)) @(negedge clock);
      fifo.push_back(a[7:0]);
      repeat ($urandom_range(0, 6)) @(negedge clock);
      fifo.push_back(a[15:8]);
      repeat ($urandom_range(0, 6)) @(negedge clock);
      fifo.push_back(b[7:0]);
      repeat ($urandom_range(0, 6)) @(negedge clock);
      fifo.push_back(b[15:8]);
      wait_quiet("rand", 300);
      chk("rand_A", 64'(dataA_o), 64'(a));
      chk("rand_B", 64'(dataB_o), 64'(b));
    end
    chk("rand_no_frame_err", 64'(err_count - e0), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Parametrised successor to the byte-wide ALU interface. Sits between the UART byte FIFOs and the combinational ALU. Assembles multi-byte operand frames (opcode, A, B) from the receive stream, validates the opcode, and presents registered operands to the ALU. Returns the multi-byte result plus a status byte over the transmit side, with an inter-byte timeout that discards stalled frames.

## Interface

Parameters:
- `N_BITS_DATA`, 16: operand/result width; multiple of 8, range 8..64. `N_BYTES = N_BITS_DATA/8` (localparam).
- `N_BITS_OP`, 6: ALU opcode width; ≤ 8.
- `TIMEOUT_CYCLES`, 100000: max idle cycles between bytes of one frame; 0 disables the timeout.

Ports:
- `clock`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: asynchronous, active-low; while 0, all state and outputs are forced to reset values.
- `rx_empty_i`  in  1: UART RX FIFO empty.
- `rx_data_i`  in  8: RX FIFO head byte; valid while `rx_empty_i`=0.
- `rd_uart_o`  out  1: one-cycle pop of the RX FIFO head.
- `tx_data_o`  out  8: byte to transmit; held stable from start until done.
- `tx_start_o`  out  1: one-cycle transmit request.
- `tx_done_tick_i`  in  1: one-cycle pulse when the UART finishes a byte.
- `dataA_o`, `dataB_o`  out  N_BITS_DATA: registered operands to the ALU.
- `dataOp_o`  out  N_BITS_OP: registered opcode to the ALU.
- `result_alu_i`  in  N_BITS_DATA: combinational ALU result.
- `busy_o`  out  1: high in any state other than IDLE.
- `frame_err_o`  out  1: one-cycle pulse on timeout discard.

## Operation

- Frame format, RX: 1 opcode byte, then N_BYTES of A (LSB first), then N_BYTES of B (LSB first).
- Response, TX: N_BYTES of result (LSB first), then 1 status byte.
  - 0x00 = OK.
  - 0x01 = BAD_OP; result bytes are sent as 0x00.
- Opcode is valid iff its upper `8-N_BITS_OP` bits are 0 and the low bits are one of: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRA 0x03, SRL 0x02.
- A bad opcode does not abort the frame. Operands are still consumed so framing stays aligned.
- FSM states:
  - IDLE → GET_OP on byte available.
  - GET_OP → GET_A.
  - GET_A (count N_BYTES) → GET_B.
  - GET_B (count N_BYTES) → EXEC.
  - EXEC → SEND.
  - SEND → WAIT_DONE.
  - WAIT_DONE → SEND, or → IDLE after the status byte.
- RX pop rule:
  - `rd_uart_o`=1 for one cycle when `rx_empty_i`=0, the state is IDLE/GET_OP/GET_A/GET_B, and `rd_uart_o` was 0 in the previous cycle.
  - This allows at most one byte per 2 cycles.
  - The byte is captured on the same edge as the pop.
- Operand assembly: byte k is written to bits [8k+7:8k]. `dataA_o`/`dataB_o`/`dataOp_o` update as bytes arrive. A new frame's opcode byte zeroes A and B.
- EXEC: latch `result_alu_i` (or 0 if BAD_OP) into an internal result register.
- RX is ignored (no pops) during EXEC/SEND/WAIT_DONE. Bytes wait in the FIFO.
- Timeout:
  - The counter resets on every pop and counts in GET_A/GET_B.
  - Reaching TIMEOUT_CYCLES discards the partial frame: go to IDLE, pulse `frame_err_o`, send nothing.
- `tx_done_tick_i` outside WAIT_DONE is ignored.

## Timing

- Reset values: `rd_uart_o`=0, `tx_start_o`=0, `tx_data_o`=0x00, `dataA_o`=0, `dataB_o`=0, `dataOp_o`=0, `busy_o`=0, `frame_err_o`=0, state IDLE.
- Last B byte popped at edge t:
  - EXEC during cycle t+1.
  - `tx_start_o` high during cycle t+2, with byte 0 on `tx_data_o`.
- Next `tx_start_o` is in the cycle after `tx_done_tick_i`.
- Total TX bytes per frame = N_BYTES+1.
- Timeout fires on the cycle the counter equals TIMEOUT_CYCLES. A pop in that same cycle wins, and the counter resets.
- Reset asserted mid-frame or mid-send: immediate return to reset values. A UART byte already in flight is not recalled.

## Structure

- Package `alu_seq_pkg` holds:
  - state enum;
  - STATUS_OK / STATUS_BAD_OP constants;
  - opcode constants and the `is_valid_op` function.
- One sub-module, `alu_seq_rx_timer`: loadable timeout counter with enable, clear and `expired` output; tied to 0 when TIMEOUT_CYCLES=0.
- Top FSM, operand shift/assembly and TX byte mux stay in `alu_cmd_sequencer`.

## Test plan

All scenarios use N_BITS_DATA=16.

- ADD: RX 0x20,0x34,0x12,0x01,0x00 → A=0x1234, B=0x0001; TX 0x35,0x12,0x00.
- SUB with wrap: RX 0x22,0x00,0x00,0x01,0x00 → TX 0xFF,0xFF,0x00.
- Bad opcode: RX 0xE0,0x11,0x22,0x33,0x44 → exactly 5 pops; TX 0x00,0x00,0x01.
- Timeout: RX 0x20,0x34, then no bytes for TIMEOUT_CYCLES (set to 50) → `frame_err_o` pulse, no TX. A following full ADD frame responds correctly.
- Back-to-back: two frames preloaded in the FIFO (`rx_empty_i` held 0) → pops never in consecutive cycles. No pops during SEND/WAIT_DONE. Two correct 3-byte responses.
- Reset mid-send: `reset`=0 after the first result byte → all outputs at reset values next cycle. A new frame after release works.
